// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode encoding, init patterns and speed limits for the LED sequencer
package led_seq_pkg;
  typedef enum logic [1:0] {PASS = 2'b00, CHASE = 2'b01, BLINK = 2'b10, COUNT = 2'b11} mode_t;
  localparam logic [3:0] CHASE_INIT = 4'b0001;
  localparam logic [3:0] BLINK_INIT = 4'b0000;
  localparam logic [3:0] COUNT_INIT = 4'b0000;
  localparam int SPD_W = 2;
  localparam logic [SPD_W-1:0] SPD_MAX = 2'd3;
  function automatic logic [3:0] init_pat(input logic [1:0] m);
    return m == CHASE ? CHASE_INIT : m == BLINK ? BLINK_INIT : COUNT_INIT;
  endfunction
endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: switch inputs and LED outputs of the Go Board I/O set
// master drives sw1..sw4 and observes led1..led4; slave is the sequencer side
interface led_sequencer_if;
  logic sw1, sw2, sw3, sw4;
  logic led1, led2, led3, led4;
  modport master(output sw1, sw2, sw3, sw4, input led1, led2, led3, led4);
  modport slave(input sw1, sw2, sw3, sw4, output led1, led2, led3, led4);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: 2-flop synchroniser, debounce and press pulse for one switch
// ports: clk, rst (async, active-high), raw (pad), stable (debounced level), press (1-cycle 0->1 pulse)
// LED_SEQ_DEBOUNCE_EN: when undefined, stable is the synchronised level and no counter is built
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic press
);
  logic s1, s2, prev;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {raw, s1, stable};
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= 1'b0;
      cnt <= '0;
    end else if (s2 == st) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      st <= s2;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
  assign stable = st;
`else
  assign stable = s2;
`endif
  assign press = stable & ~prev;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: switch-driven LED pattern generator (pass, chase, blink, binary count)
// ports: clk, rst (async, active-high), bus (led_sequencer_if.slave: sw1..sw4 in, led1..led4 out)
// LED_SEQ_DEBOUNCE_EN: selects the counter-based debounce in sw_debounce
module led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_BASE = 2500000
) (
  input logic clk,
  input logic rst,
  led_sequencer_if.slave bus
);
  import led_seq_pkg::*;
  localparam logic [1:0] M_PASS = PASS;
  localparam logic [1:0] M_CHASE = CHASE;
  localparam logic [1:0] M_BLINK = BLINK;
  localparam int TW = $clog2(TICK_BASE);
  if (TICK_BASE < 8) begin : g_bad
    $error("TICK_BASE must be at least 8");
  end
  logic [3:0] raw, st, pr, pat, pat_step, led;
  logic [1:0] mode;
  logic [SPD_W-1:0] spd, spd_nxt;
  logic paused, tick;
  logic [TW-1:0] tcnt, last;
  assign raw = {bus.sw4, bus.sw3, bus.sw2, bus.sw1};
  for (genvar i = 0; i < 4; i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(raw[i]), .stable(st[i]), .press(pr[i])
    );
  end
  always_comb begin
    spd_nxt = pr[1] & ~pr[2] & (spd != SPD_MAX) ? spd + 1'b1 :
              pr[2] & ~pr[1] & (spd != '0) ? spd - 1'b1 : spd;
    last = TW'((TICK_BASE >> spd) - 1);
    tick = ~paused & (tcnt == last);
    pat_step = mode == M_CHASE ? {pat[2:0], pat[3]} : mode == M_BLINK ? ~pat : pat + 4'd1;
  end
  // a mode change takes priority over a coincident tick: the new init pattern loads, the step is lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode <= M_PASS;
      spd <= '0;
      paused <= 1'b0;
      tcnt <= '0;
      pat <= '0;
      led <= '0;
    end else begin
      mode <= pr[0] ? mode + 2'd1 : mode;
      spd <= spd_nxt;
      paused <= paused ^ pr[3];
      tcnt <= pr[0] | (spd_nxt != spd) | paused | pr[3] | tick ? '0 : tcnt + 1'b1;
      pat <= pr[0] ? init_pat(mode + 2'd1) : tick & (mode != M_PASS) ? pat_step : pat;
      led <= mode == M_PASS ? st : pat;
    end
  assign {bus.led4, bus.led3, bus.led2, bus.led1} = led;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized and directed checks of led_sequencer against a behavioural model
module tb_led_sequencer;
  localparam int DB = 4;
  localparam int TB = 16;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw;
  logic [3:0] leds;
  int checks = 0;
  int failures = 0;
  led_sequencer_if bus();
  led_sequencer #(.DEBOUNCE_CYCLES(DB), .TICK_BASE(TB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.sw1 = sw[0];
  assign bus.sw2 = sw[1];
  assign bus.sw3 = sw[2];
  assign bus.sw4 = sw[3];
  assign leds = {bus.led4, bus.led3, bus.led2, bus.led1};
  always #5 clk = ~clk;

  int m_s1[4], m_s2[4], m_st[4], m_run[4], m_prev[4];
  int m_mode, m_spd, m_paused, m_phase, m_pat, m_led;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0; m_prev[i] = 0;
    end
    m_mode = 0; m_spd = 0; m_paused = 0; m_phase = 0; m_pat = 0; m_led = 0;
  endtask

  // one clock edge of the behavioural model, using the switch levels present before the edge
  task automatic model_step();
    int cur[4], prs[4];
    int per, spd_n, paused_n, tk;
    for (int i = 0; i < 4; i++) begin
      cur[i] = DBL > 0 ? m_st[i] : m_s2[i];
      prs[i] = (cur[i] != 0 && m_prev[i] == 0) ? 1 : 0;
    end
    per = TB >> m_spd;
    tk = (m_paused == 0 && m_phase == per - 1) ? 1 : 0;
    m_led = m_mode == 0 ? cur[0] + 2 * cur[1] + 4 * cur[2] + 8 * cur[3] : m_pat;
    spd_n = m_spd;
    if (prs[1] != 0 && prs[2] == 0) spd_n = m_spd < 3 ? m_spd + 1 : 3;
    if (prs[2] != 0 && prs[1] == 0) spd_n = m_spd > 0 ? m_spd - 1 : 0;
    paused_n = prs[3] != 0 ? 1 - m_paused : m_paused;
    if (prs[0] != 0) begin
      m_mode = (m_mode + 1) % 4;
      m_pat = m_mode == 1 ? 1 : 0;
    end else if (tk != 0 && m_mode != 0)
      m_pat = m_mode == 1 ? (m_pat * 2) % 16 + m_pat / 8 : m_mode == 2 ? 15 - m_pat : (m_pat + 1) % 16;
    m_phase = (prs[0] != 0 || spd_n != m_spd || m_paused != 0 || paused_n != 0) ? 0 : (m_phase + 1) % per;
    m_spd = spd_n;
    m_paused = paused_n;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = cur[i];
      if (DBL > 0) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DBL) begin
            m_st[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = int'(sw[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("led", int'(leds), m_led);
    check("mode", int'(dut.mode), m_mode);
    check("spd", int'(dut.spd), m_spd);
    check("paused", int'(dut.paused), m_paused);
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int i);
    sw[i] = 1'b1;
    hold(DB + 4);
    sw[i] = 1'b0;
    hold(DB + 4);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_led", int'(leds), 0);
    check("rst_mode", int'(dut.mode), 0);
    hold(3);
    rst = 1'b0;
  endtask

  // cycles between the next two LED changes
  task automatic interval(output int n);
    int k;
    logic [3:0] v;
    k = 0;
    v = leds;
    while (leds == v && k < 200) begin cyc(); k++; end
    v = leds;
    n = 0;
    while (leds == v && n < 200) begin cyc(); n++; end
  endtask

  initial begin
    int n, seen, ri;
    logic [3:0] v;
    sw = 4'b0000;
    model_reset();
    hold(3);
    check("reset_led", int'(leds), 0);
    rst = 1'b0;
    hold(4);
    sw = 4'b1010;
    hold(DB + 6);
    check("pre_rst", int'(leds), 10);
    sw = 4'b0000;
    async_reset();
    hold(DB + 6);
    sw[2] = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!leds[2] && n < 60);
    check("pass_lat", n, DBL + 3);
    sw[2] = 1'b0;
    hold(DB + 6);
    sw[0] = 1'b1;
    seen = 0;
    repeat (3) begin cyc(); if (leds[0]) seen = 1; end
    sw[0] = 1'b0;
    repeat (12) begin cyc(); if (leds[0]) seen = 1; end
    check("glitch_led1", seen, DBL > 0 ? 0 : 1);
    check("glitch_mode", int'(dut.mode), DBL > 0 ? 0 : 1);
    while (m_mode != 0) press(0);
    sw[3] = 1'b1;
    cyc();
    sw[3] = 1'b0;
    seen = 0;
    repeat (12) begin cyc(); if (leds[3]) seen = 1; end
    check("pulse_led4", seen, DBL > 0 ? 0 : 1);
    if (m_paused != 0) press(3);
    press(0);
    check("chase_mode", int'(dut.mode), 1);
    interval(n);
    check("chase_int16", n, 16);
    hold(40);
    press(1);
    press(1);
    interval(n);
    check("chase_int4", n, 4);
    press(1);
    press(1);
    interval(n);
    check("chase_int2", n, 2);
    check("spd_sat", int'(dut.spd), 3);
    press(0);
    press(0);
    check("count_mode", int'(dut.mode), 3);
    n = 0;
    while (leds != 4'hF && n < 100) begin cyc(); n++; end
    while (leds == 4'hF && n < 100) begin cyc(); n++; end
    check("count_wrap", int'(leds), 0);
    press(3);
    v = leds;
    hold(70);
    check("pause_hold", int'(leds), int'(v));
    sw[3] = 1'b1;
    n = 0;
    while (dut.paused && n < 50) begin cyc(); n++; end
    check("unpaused", int'(dut.paused), 0);
    v = leds;
    n = 0;
    while (leds == v && n < 50) begin cyc(); n++; end
    check("resume_lat", n, (TB >> 3) + 1);
    sw[3] = 1'b0;
    hold(DB + 6);
    press(0);
    check("cycle_pass", int'(dut.mode), 0);
    for (int k = 1; k <= 4; k++) begin
      press(0);
      check("cycle_mode", int'(dut.mode), k % 4);
    end
    press(0);
    for (int k = 0; k < 8; k++) begin
      sw[0] = 1'b1;
      hold(DB + 4);
      sw[0] = 1'b0;
      hold(DB + 4 + k % 3);
    end
    press(2);
    sw[1] = 1'b1;
    sw[2] = 1'b1;
    hold(DB + 4);
    sw[1] = 1'b0;
    sw[2] = 1'b0;
    hold(DB + 4);
    check("spd_both", int'(dut.spd), 2);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        ri = $urandom_range(3);
        sw[ri] = ~sw[ri];
      end
      if (c == 1500) begin
        sw = 4'b0000;
        async_reset();
      end
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
